backbone_product_seq: RTL

BACKBONE_PRODUCT_SEQ -- requirements
Module: backbone_product_seq

---
 rtl/backbone_pkg.sv | 23 ++
 rtl/fix_mul_sat.sv | 28 ++
 rtl/backbone_product_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/backbone_pkg.sv
// Shared definitions for the backbone product sequencer: state encoding and
// a constant-function ceiling log2 used to size index ports.
package backbone_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPUTE = 2'b01,
    OUT     = 2'b10
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fix_mul_sat.sv
// Unsigned fixed-point multiply: (a * b) >> FRAC_B, truncated, clamped to the
// width of a. Returns {sat, result}.
module fix_mul_sat #(
  parameter int unsigned DW_A   = 32,
  parameter int unsigned DW_B   = 8,
  parameter int unsigned FRAC_B = 7
) (
  input  logic [DW_A-1:0] a,
  input  logic [DW_B-1:0] b,
  output logic [DW_A:0]   res_c
);

  localparam int unsigned PW = DW_A + DW_B;

  logic [PW-1:0] prod;
  logic [PW-1:0] shifted;

  always_comb begin
    prod    = PW'(a) * PW'(b);
    shifted = prod >> FRAC_B;
    if (shifted > PW'({DW_A{1'b1}})) begin
      res_c = {1'b1, {DW_A{1'b1}}};
    end else begin
      res_c = {1'b0, shifted[DW_A-1:0]};
    end
  end

endmodule

// File: rtl/backbone_product_seq.sv
// Sequential fixed-point product of the selected element at every backbone
// position except ind_j; one position per cycle, so latency is fixed at J+1.
module backbone_product_seq
  import backbone_pkg::*;
#(
  parameter int unsigned J        = 14,
  parameter int unsigned A        = 2,
  parameter int unsigned DW_IN    = 8,
  parameter int unsigned FRAC_IN  = 7,
  parameter int unsigned DW_OUT   = 32,
  parameter int unsigned FRAC_OUT = 28,
  localparam int unsigned J_WIDTH = clog2(J) + 1,
  localparam int unsigned A_WIDTH = clog2(A) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [J*A*DW_IN-1:0]    alpha_u,
  input  logic [J*A_WIDTH-1:0]    x_initial,
  input  logic [J_WIDTH-1:0]      ind_j,
  input  logic                    din_tvalid,
  output logic                    din_tready,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [DW_OUT-1:0]       m_tdata,
  output logic                    m_overflow,
  output logic                    m_sym_err
);

  localparam logic [DW_OUT-1:0] ACC_ONE = DW_OUT'(1) << FRAC_OUT;

  state_e                 state_q, state_d;
  logic [J*A*DW_IN-1:0]   alpha_q, alpha_d;
  logic [J*A_WIDTH-1:0]   x_q, x_d;
  logic [J_WIDTH-1:0]     ind_q, ind_d;
  logic [DW_OUT-1:0]      acc_q, acc_d;
  logic [J_WIDTH-1:0]     k_q, k_d;
  logic                   ovf_q, ovf_d;
  logic                   err_q, err_d;
  logic                   din_tready_d;
  logic                   m_tvalid_d;
  logic [DW_OUT-1:0]      m_tdata_d;
  logic                   m_overflow_d;
  logic                   m_sym_err_d;

  logic [A_WIDTH-1:0]     sym_c;
  logic [A_WIDTH-1:0]     sel_c;
  logic                   sym_bad_c;
  logic [DW_IN-1:0]       elem_c;
  logic [DW_OUT:0]        mul_c;

  // Element mux for position k; out-of-range symbols fall back to index 0.
  always_comb begin
    sym_c = '0;
    for (int unsigned j = 0; j < J; j++) begin
      if (k_q == J_WIDTH'(j)) sym_c = x_q[j*A_WIDTH +: A_WIDTH];
    end
    sym_bad_c = (sym_c >= A_WIDTH'(A));
    sel_c     = sym_bad_c ? '0 : sym_c;
    elem_c    = '0;
    for (int unsigned j = 0; j < J; j++) begin
      for (int unsigned a = 0; a < A; a++) begin
        if (k_q == J_WIDTH'(j) && sel_c == A_WIDTH'(a)) begin
          elem_c = alpha_q[(j*A+a)*DW_IN +: DW_IN];
        end
      end
    end
  end

  fix_mul_sat #(
    .DW_A   (DW_OUT),
    .DW_B   (DW_IN),
    .FRAC_B (FRAC_IN)
  ) u_mul (
    .a     (acc_q),
    .b     (elem_c),
    .res_c (mul_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    alpha_d      = alpha_q;
    x_d          = x_q;
    ind_d        = ind_q;
    acc_d        = acc_q;
    k_d          = k_q;
    ovf_d        = ovf_q;
    err_d        = err_q;
    m_tdata_d    = m_tdata;
    m_overflow_d = m_overflow;
    m_sym_err_d  = m_sym_err;

    case (state_q)
      IDLE: begin
        if (din_tready && din_tvalid) begin
          alpha_d = alpha_u;
          x_d     = x_initial;
          ind_d   = ind_j;
          acc_d   = ACC_ONE;
          k_d     = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        // Skipped position is a no-op cycle; a zero accumulator stays zero.
        if (k_q != ind_q) begin
          if (sym_bad_c) err_d = 1'b1;
          if (acc_q != '0) begin
            acc_d = mul_c[DW_OUT-1:0];
            if (mul_c[DW_OUT]) ovf_d = 1'b1;
          end
        end
        if (k_q == J_WIDTH'(J - 1)) begin
          k_d          = '0;
          state_d      = OUT;
          m_tdata_d    = acc_d;
          m_overflow_d = ovf_d;
          m_sym_err_d  = err_d;
        end else begin
          k_d = k_q + J_WIDTH'(1);
        end
      end
      OUT: begin
        if (m_tready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    din_tready_d = (state_d == IDLE);
    m_tvalid_d   = (state_d == OUT);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      alpha_q    <= '0;
      x_q        <= '0;
      ind_q      <= '0;
      acc_q      <= '0;
      k_q        <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      din_tready <= 1'b0;
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      m_overflow <= 1'b0;
      m_sym_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alpha_q    <= alpha_d;
      x_q        <= x_d;
      ind_q      <= ind_d;
      acc_q      <= acc_d;
      k_q        <= k_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      din_tready <= din_tready_d;
      m_tvalid   <= m_tvalid_d;
      m_tdata    <= m_tdata_d;
      m_overflow <= m_overflow_d;
      m_sym_err  <= m_sym_err_d;
    end
  end

endmodule
